// File: rtl/matrix_mul_seq.sv
// Sequential C = A x B using one shared MAC unit walked by a small FSM (k innermost, then j, then i).
// Optional macro MATRIX_MUL_SAT_EN clamps out-of-range results instead of truncating them.
module matrix_mul_seq #(
  parameter int BITLENGTH = 8,
  parameter int M1_D1     = 4,
  parameter int M1_D2     = 2,
  parameter int M2_D2     = 3,
  parameter int ACC_WIDTH = 20,
  parameter int SIGNED    = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [M1_D1*M1_D2*BITLENGTH-1:0]    a_in,
  input  logic [M1_D2*M2_D2*BITLENGTH-1:0]    b_in,
  output logic                                busy,
  output logic                                done,
  output logic [M1_D1*M2_D2*BITLENGTH-1:0]    c_out,
  output logic                                ovf
);

  localparam int AW = M1_D1*M1_D2*BITLENGTH;
  localparam int BW = M1_D2*M2_D2*BITLENGTH;
  localparam int CW = M1_D1*M2_D2*BITLENGTH;
  localparam int IW = (M1_D1 > 1) ? $clog2(M1_D1) : 1;
  localparam int JW = (M2_D2 > 1) ? $clog2(M2_D2) : 1;
  localparam int KW = (M1_D2 > 1) ? $clog2(M1_D2) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(M1_D1-1);
  localparam logic [JW-1:0] J_LAST = JW'(M2_D2-1);
  localparam logic [KW-1:0] K_LAST = KW'(M1_D2-1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_a;
  logic [BW-1:0]          r_b;
  logic [CW-1:0]          r_c;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [IW-1:0]          r_i;
  logic [JW-1:0]          r_j;
  logic [KW-1:0]          r_k;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;

  logic [BITLENGTH-1:0]   w_aElem;
  logic [BITLENGTH-1:0]   w_bElem;
  logic [ACC_WIDTH-1:0]   w_aExt;
  logic [ACC_WIDTH-1:0]   w_bExt;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_ovf;
  logic [BITLENGTH-1:0]   w_res;

  // Operands are extended to the accumulator width first, so the low bits of the product are exact in both modes.
  always_comb begin
    w_aElem = BITLENGTH'(r_a >> ((int'(r_i)*M1_D2 + int'(r_k))*BITLENGTH));
    w_bElem = BITLENGTH'(r_b >> ((int'(r_k)*M2_D2 + int'(r_j))*BITLENGTH));
    if (SIGNED != 0) begin
      w_aExt = {{(ACC_WIDTH-BITLENGTH){w_aElem[BITLENGTH-1]}}, w_aElem};
      w_bExt = {{(ACC_WIDTH-BITLENGTH){w_bElem[BITLENGTH-1]}}, w_bElem};
    end else begin
      w_aExt = {{(ACC_WIDTH-BITLENGTH){1'b0}}, w_aElem};
      w_bExt = {{(ACC_WIDTH-BITLENGTH){1'b0}}, w_bElem};
    end
    w_sum = r_acc + w_aExt * w_bExt;
    if (SIGNED != 0) begin
      w_ovf = !((&w_sum[ACC_WIDTH-1:BITLENGTH-1]) || !(|w_sum[ACC_WIDTH-1:BITLENGTH-1]));
    end else begin
      w_ovf = |w_sum[ACC_WIDTH-1:BITLENGTH];
    end
    w_res = w_sum[BITLENGTH-1:0];
`ifdef MATRIX_MUL_SAT_EN
    if (w_ovf) begin
      if (SIGNED != 0) begin
        w_res = w_sum[ACC_WIDTH-1] ? {1'b1, {(BITLENGTH-1){1'b0}}} : {1'b0, {(BITLENGTH-1){1'b1}}};
      end else begin
        w_res = '1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (r_k == K_LAST) begin
            for (int e = 0; e < M1_D1*M2_D2; e++) begin
              if (e == int'(r_i)*M2_D2 + int'(r_j)) begin
                r_c[e*BITLENGTH +: BITLENGTH] <= w_res;
              end
            end
            if (w_ovf) begin
              r_ovf <= 1'b1;
            end
            r_acc <= '0;
            r_k   <= '0;
            if (r_j == J_LAST) begin
              r_j <= '0;
              if (r_i == I_LAST) begin
                r_i     <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_i <= r_i + IW'(1);
              end
            end else begin
              r_j <= r_j + JW'(1);
            end
          end else begin
            r_acc <= w_sum;
            r_k   <= r_k + KW'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign ovf   = r_ovf;
  assign c_out = r_c;

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Directed bench for matrix_mul_seq: an unsigned and a signed instance share the same stimulus.
// Expected clamp/truncate values follow MATRIX_MUL_SAT_EN.
module tb_matrix_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] aIn;
  logic [47:0] bIn;
  logic        busy, done, ovf;
  logic [95:0] cOut;
  logic        busyS, doneS, ovfS;
  logic [95:0] cOutS;

  int vectorCount = 0;
  int missCount   = 0;
  int doneAt, busyCnt, doneCnt;

  localparam logic [63:0] A_BASE = {8'd14, 8'd13, 8'd11, 8'd10, 8'd8, 8'd7, 8'd5, 8'd4};
  localparam logic [47:0] B_BASE = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [95:0] C_BASE = {8'd231, 8'd204, 8'd177, 8'd180, 8'd159, 8'd138,
                                    8'd129, 8'd114, 8'd99, 8'd78, 8'd69, 8'd60};
`ifdef MATRIX_MUL_SAT_EN
  localparam logic [95:0] C_ALL255 = {12{8'hFF}};
  localparam logic [95:0] C_NEG3U  = {12{8'hFF}};
`else
  localparam logic [95:0] C_ALL255 = {12{8'h02}};
  localparam logic [95:0] C_NEG3U  = {12{8'hFA}};
`endif

  matrix_mul_seq #(.SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(aIn), .b_in(bIn),
    .busy(busy), .done(done), .c_out(cOut), .ovf(ovf)
  );

  matrix_mul_seq #(.SIGNED(1)) dutS (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(aIn), .b_in(bIn),
    .busy(busyS), .done(doneS), .c_out(cOutS), .ovf(ovfS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one run from a negedge and watches it to completion, with a bounded cycle budget.
  task automatic applyStimulus(input logic [63:0] a, input logic [47:0] b, input bit holdStart,
                               input bit zeroAfter, output int dAt, output int bCnt, output int dCnt);
    aIn   = a;
    bIn   = b;
    start = 1'b1;
    dAt   = -1;
    bCnt  = 0;
    dCnt  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!holdStart) start = 1'b0;
        if (zeroAfter) begin
          aIn = '0;
          bIn = '0;
        end
      end
      if (busy) bCnt++;
      if (done) begin
        dCnt++;
        if (dAt < 0) dAt = c;
        start = 1'b0;
      end
      if (dAt > 0 && c >= dAt + 3) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    aIn   = '0;
    bIn   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {95'd0, busy}, 96'd0);
    checkOutput("reset done", {95'd0, done}, 96'd0);
    checkOutput("reset ovf", {95'd0, ovf}, 96'd0);
    checkOutput("reset c_out", cOut, 96'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(A_BASE, B_BASE, 1'b0, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("base done latency", 96'(doneAt), 96'd25);
    checkOutput("base busy cycles", 96'(busyCnt), 96'd24);
    checkOutput("base done pulses", 96'(doneCnt), 96'd1);
    checkOutput("base c_out", cOut, C_BASE);
    checkOutput("base ovf", {95'd0, ovf}, 96'd0);

    applyStimulus(A_BASE, B_BASE, 1'b0, 1'b1, doneAt, busyCnt, doneCnt);
    checkOutput("capture done latency", 96'(doneAt), 96'd25);
    checkOutput("capture c_out", cOut, C_BASE);

    applyStimulus({8{8'hFF}}, {6{8'hFF}}, 1'b0, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("all255 c_out", cOut, C_ALL255);
    checkOutput("all255 ovf", {95'd0, ovf}, 96'd1);
    checkOutput("all255 signed c_out", cOutS, {12{8'h02}});
    checkOutput("all255 signed ovf", {95'd0, ovfS}, 96'd0);

    applyStimulus({8{8'hFF}}, {6{8'h03}}, 1'b0, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("signed c_out", cOutS, {12{8'hFA}});
    checkOutput("signed ovf", {95'd0, ovfS}, 96'd0);
    checkOutput("neg3 unsigned c_out", cOut, C_NEG3U);
    checkOutput("neg3 unsigned ovf", {95'd0, ovf}, 96'd1);

    applyStimulus({8{8'hFF}}, {6{8'hFF}}, 1'b1, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("held done pulses", 96'(doneCnt), 96'd1);
    checkOutput("held busy cycles", 96'(busyCnt), 96'd24);
    checkOutput("held ovf", {95'd0, ovf}, 96'd1);

    applyStimulus(A_BASE, B_BASE, 1'b0, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("rerun ovf cleared", {95'd0, ovf}, 96'd0);
    checkOutput("rerun c_out", cOut, C_BASE);

    aIn   = {8{8'hFF}};
    bIn   = {6{8'hFF}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("pre-reset ovf", {95'd0, ovf}, 96'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {95'd0, busy}, 96'd0);
    checkOutput("async reset done", {95'd0, done}, 96'd0);
    checkOutput("async reset ovf", {95'd0, ovf}, 96'd0);
    checkOutput("async reset c_out", cOut, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post-reset idle", {95'd0, busy}, 96'd0);

    applyStimulus(A_BASE, B_BASE, 1'b0, 1'b0, doneAt, busyCnt, doneCnt);
    checkOutput("post-reset latency", 96'(doneAt), 96'd25);
    checkOutput("post-reset c_out", cOut, C_BASE);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
